// File: rtl/stim_seq_pkg.sv
// Shared types and constants for the stimulus burst sequencer.
package stim_seq_pkg;

  localparam int GAP_WIDTH = 8;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_SEND_ENC = 2'd1;
  localparam logic [1:0] ST_GAP_ENC  = 2'd2;
  localparam logic [1:0] ST_DONE_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_SEND = ST_SEND_ENC,
    ST_GAP  = ST_GAP_ENC,
    ST_DONE = ST_DONE_ENC
  } state_t;

endpackage

// File: rtl/stim_seq_gap_timer.sv
// Loadable down-counter; expire flags the final cycle of a loaded interval.
module stim_seq_gap_timer
  import stim_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 sys_rst,
  input  logic                 load,
  input  logic [GAP_WIDTH-1:0] load_val,
  output logic                 expire
);

  logic [GAP_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - GAP_WIDTH'(1);
    end
  end

  // Terminal count at 1 so a load of N yields exactly N gap cycles.
  assign expire = (cnt == GAP_WIDTH'(1));

endmodule

// File: rtl/stim_seq_ctrl.sv
// Start-triggered incrementing address/data burst over valid/ready.
// Optional inter-beat gap (gap_cfg port, GAP state) enabled by STIM_SEQ_GAP_EN.
//
// state | meaning
// IDLE  | waiting for start; config sampled on start
// SEND  | beat presented, held until handshake
// GAP   | idle cycles between beats (STIM_SEQ_GAP_EN only)
// DONE  | one-cycle completion pulse
module stim_seq_ctrl
  import stim_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DATA_WIDTH-1:0] base_data,
  input  logic [LEN_WIDTH-1:0]  beat_cnt,
`ifdef STIM_SEQ_GAP_EN
  input  logic [GAP_WIDTH-1:0]  gap_cfg,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic                  accept;
  logic                  hs;
  logic                  last_beat;

  assign accept    = (state_q == ST_IDLE) && start && (beat_cnt != '0);
  assign last_beat = (remaining_q == LEN_WIDTH'(1));
  assign hs        = out_valid && out_ready;

`ifdef STIM_SEQ_GAP_EN
  logic [GAP_WIDTH-1:0] gap_q;
  logic                 gap_expire;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      gap_q <= '0;
    end else if (accept) begin
      gap_q <= gap_cfg;
    end
  end

  stim_seq_gap_timer u_gap_timer (
    .clk      (clk),
    .sys_rst  (sys_rst),
    .load     (hs),
    .load_val (gap_q),
    .expire   (gap_expire)
  );
`endif

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (beat_cnt != '0) ? ST_SEND : ST_DONE;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (last_beat) begin
            state_d = ST_DONE;
          end else begin
`ifdef STIM_SEQ_GAP_EN
            state_d = (gap_q != '0) ? ST_GAP : ST_SEND;
`else
            state_d = ST_SEND;
`endif
          end
        end
      end
      ST_GAP: begin
`ifdef STIM_SEQ_GAP_EN
        if (gap_expire) begin
          state_d = ST_SEND;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == ST_SEND);
    out_last  = (state_q == ST_SEND) && last_beat;
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
  end

  // Beat counters; increments wrap silently at the field width.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      addr_q      <= '0;
      data_q      <= '0;
      remaining_q <= '0;
    end else if (accept) begin
      addr_q      <= base_addr;
      data_q      <= base_data;
      remaining_q <= beat_cnt;
    end else if (hs) begin
      addr_q      <= addr_q + ADDR_WIDTH'(1);
      data_q      <= data_q + DATA_WIDTH'(1);
      remaining_q <= remaining_q - LEN_WIDTH'(1);
    end
  end

  assign out_addr = addr_q;
  assign out_data = data_q;

endmodule

// File: doc/stim_seq_ctrl.md
# stim_seq_ctrl

Sequencer that drives an incrementing address/data write stream into a DUT over a valid/ready handshake, replacing free-running stimulus counters with a controlled, start-triggered burst. On a start pulse it latches base address, base data and beat count, issues exactly that many beats with address and data each incrementing by one per accepted beat, then pulses done. It sits between test control (or an embedded self-test) and the DUT's write port.

## Interface
- DATA_WIDTH, 32, width of out_data and base_data
- ADDR_WIDTH, 32, width of out_addr and base_addr
- LEN_WIDTH, 16, width of beat_cnt
- clk  in  1  system clock, rising edge
- sys_rst  in  1  reset, synchronous and active-high
- start  in  1  request pulse, sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first beat address
- base_data  in  DATA_WIDTH  first beat data
- beat_cnt  in  LEN_WIDTH  number of beats, 0 allowed
- gap_cfg  in  8  idle cycles inserted between beats (present only with STIM_SEQ_GAP_EN)
- out_valid  out  1  beat valid
- out_ready  in  1  DUT accepts beat
- out_addr  out  ADDR_WIDTH  beat address
- out_data  out  DATA_WIDTH  beat data
- out_last  out  1  high with final beat
- busy  out  1  burst in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SEND, GAP (macro only), DONE.
- IDLE: start=1 and beat_cnt!=0 -> latch base_addr, base_data, beat_cnt (and gap_cfg); go SEND. start=1 and beat_cnt=0 -> go DONE directly, no beats issued.
- SEND: out_valid=1; out_addr/out_data/out_last held stable until out_valid&out_ready. On handshake: addr+=1, data+=1, remaining-=1, all modulo 2^width (wrap from all-ones to 0 is silent). Non-last handshake -> stay SEND (or GAP if gap_cfg!=0). Last handshake -> DONE.
- out_last=1 exactly when remaining==1 and out_valid=1.
- GAP: out_valid=0 for gap_cfg cycles, then SEND.
- DONE: done=1 for one cycle, then IDLE.
- start outside IDLE (including DONE) is ignored; config inputs are don't-care outside the latch cycle.
- sys_rst in any state: next edge state=IDLE, out_valid=0, out_last=0, busy=0, done=0, out_addr=0, out_data=0, internal counters=0; any partially issued burst is abandoned.

## Timing
- Reset values: all outputs 0.
- start at edge T (in IDLE) -> out_valid=1 with base values from cycle T+1.
- Throughput one beat per cycle with out_ready held high and no gap.
- busy=1 from first cycle after start through the DONE cycle inclusive; 0 in IDLE.
- Last handshake at cycle L -> done=1 in cycle L+1; new start accepted from cycle L+2.
- beat_cnt=0: start at T -> done=1 in cycle T+1, out_valid never asserted.
- out_ready low never changes out_addr/out_data/out_last while out_valid=1.

## Configuration
- STIM_SEQ_GAP_EN defined: gap_cfg port and GAP state exist; after each non-last handshake, out_valid drops for exactly gap_cfg cycles (gap_cfg=0 means back-to-back). No gap after the last beat.
- Not defined: no gap_cfg port, no GAP state; beats always back-to-back subject only to out_ready.

## Structure
- Package stim_seq_pkg: state enum typedef, state encoding constants, gap-width constant (8).
- Sub-module stim_seq_gap_timer: loadable down-counter asserting expire; instantiated only under STIM_SEQ_GAP_EN.

## Test plan
- base_addr=0x100, base_data=0xA0, beat_cnt=4, out_ready=1 -> addr 0x100..0x103, data 0xA0..0xA3 on four consecutive cycles, out_last on 4th, done one cycle later.
- Same burst, out_ready toggling 1,0,0,1,... -> each beat held stable while ready low; still exactly 4 beats, no skips or duplicates.
- base_addr=0xFFFFFFFE, beat_cnt=3 -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- beat_cnt=0, start pulse -> done=1 next cycle, out_valid stays 0, busy high only during that one cycle.
- sys_rst asserted after 2 of 8 beats -> next cycle all outputs 0, IDLE; new start then replays from new base.
- With STIM_SEQ_GAP_EN, gap_cfg=2, beat_cnt=3, out_ready=1 -> valid pattern 1,0,0,1,0,0,1 then done.
